// File: rtl/floor_pkg.sv
// floor_pkg
//   Shared definitions for the elevator floor datapath: floor code width,
//   number of floors, the floor code type, the default request-store depth
//   and the floor value used on reset / when the store is empty.
//   Reused by the request memory, the floor comparator and the controller.
package floor_pkg;

  localparam int FLOOR_W       = 2;
  localparam int NUM_FLOORS    = 2 ** FLOOR_W;
  localparam int DEPTH_DEFAULT = 4;

  typedef logic [FLOOR_W-1:0] floor_t;

  localparam floor_t FLOOR_RESET = '0;

endpackage : floor_pkg

// File: rtl/floor_mem_ptr_ctrl.sv
// floor_mem_ptr_ctrl
//   Pointer and occupancy control for the circular floor-request deque.
//   Decides whether a push / pop is accepted, updates head, tail and count,
//   tells the storage array where to write, and produces the registered
//   overflow / underflow pulses.
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   push                request to insert (already filtered by the top)
//   push_front          1 = insert at front, 0 = insert at back
//   pop                 request to remove the front entry
//   head                index of the front entry
//   count               number of entries held
//   full, empty         occupancy status
//   overflow_flag       1-cycle pulse: push dropped because the store was full
//   underflow_flag      1-cycle pulse: pop requested while empty
//   wr_en, wr_addr      storage write strobe and slot for the accepted push
module floor_mem_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_front,
  input  logic             pop,
  output logic [PTR_W-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow_flag,
  output logic             underflow_flag,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_addr
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_next, tail_next;
  logic [CNT_W-1:0] count_next;
  logic             pop_ok, push_ok, front_ins;
  logic             overflow_next, underflow_next;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // NOTE: every output of this block gets a default first so that no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    pop_ok     = pop && !empty;
    // A pop in the same cycle frees a slot, so a full store still accepts.
    push_ok    = push && (!full || pop_ok);
    // On an empty store front and back insertion coincide: the entry lands
    // at head and tail moves to head+1, which is exactly a back insert.
    front_ins  = push_front && !empty;

    head_next      = head;
    tail_next      = tail;
    count_next     = count;
    wr_en          = 1'b0;
    wr_addr        = tail;
    overflow_next  = push && !push_ok;
    underflow_next = pop && empty;

    if (push_ok && pop_ok) begin
      wr_en = 1'b1;
      if (front_ins) begin
        // Replace the departing front entry in place; pointers stay put.
        wr_addr = head;
      end else begin
        wr_addr   = tail;
        head_next = head + PTR_ONE;
        tail_next = tail + PTR_ONE;
      end
    end else if (push_ok) begin
      wr_en      = 1'b1;
      count_next = count + CNT_ONE;
      if (front_ins) begin
        wr_addr   = head - PTR_ONE;
        head_next = head - PTR_ONE;
      end else begin
        wr_addr   = tail;
        tail_next = tail + PTR_ONE;
      end
    end else if (pop_ok) begin
      head_next  = head + PTR_ONE;
      count_next = count - CNT_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
    end else begin
      head           <= head_next;
      tail           <= tail_next;
      count          <= count_next;
      overflow_flag  <= overflow_next;
      underflow_flag <= underflow_next;
    end
  end

endmodule : floor_mem_ptr_ctrl

// File: rtl/floor_request_memory.sv
// floor_request_memory
//   Ordered store of pending elevator destination floors, organised as a
//   circular deque. The front entry (pos0Mem) feeds the floor comparator,
//   whose beginEndMemory_Flag selects front or back insertion; the
//   controller pops the front entry when the car reaches that floor.
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   floor_destiny_Input  requested floor
//   request_valid        1-cycle strobe: insert floor_destiny_Input
//   beginEndMemory_Flag  1 = insert at front, 0 = insert at back
//   floor_reached        1-cycle strobe: pop the front entry
//   pos0Mem              front entry, FLOOR_RESET when empty
//   mem_count            entries held
//   mem_empty, mem_full  occupancy status
//   overflow_Flag        1-cycle pulse: insert dropped (store full)
//   underflow_Flag       1-cycle pulse: pop while empty
// Configuration
//   DUPLICATE_FILTER_EN  when defined, a request whose floor is already
//                        stored is discarded silently; an entry being popped
//                        in the same cycle does not count as stored.
module floor_request_memory
  import floor_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  floor_t                   floor_destiny_Input,
  input  logic                     request_valid,
  input  logic                     beginEndMemory_Flag,
  input  logic                     floor_reached,
  output floor_t                   pos0Mem,
  output logic [$clog2(DEPTH):0]   mem_count,
  output logic                     mem_empty,
  output logic                     mem_full,
  output logic                     overflow_Flag,
  output logic                     underflow_Flag
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  floor_t           storage [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] wr_addr;
  logic             wr_en;
  logic             duplicate;
  logic             push;

`ifdef DUPLICATE_FILTER_EN
  logic             pop_ok;
  logic [PTR_W-1:0] offset;

  assign pop_ok = floor_reached && !mem_empty;

  always_comb begin
    duplicate = 1'b0;
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // Slot i holds a live entry when its distance from head is below count.
      offset = PTR_W'(i) - head;
      if ((CNT_W'(offset) < mem_count) && (storage[i] == floor_destiny_Input) &&
          !(pop_ok && (PTR_W'(i) == head))) begin
        duplicate = 1'b1;
      end
    end
  end
`else
  assign duplicate = 1'b0;
`endif

  assign push = request_valid && !duplicate;

  floor_mem_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk            (clk),
    .reset          (reset),
    .push           (push),
    .push_front     (beginEndMemory_Flag),
    .pop            (floor_reached),
    .head           (head),
    .count          (mem_count),
    .full           (mem_full),
    .empty          (mem_empty),
    .overflow_flag  (overflow_Flag),
    .underflow_flag (underflow_Flag),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr)
  );

  // NOTE: the storage array is cleared on reset on purpose: the comparator
  // and the duplicate filter must never see stale floors after a reset, and
  // the array is small enough to live in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      storage <= '{default: FLOOR_RESET};
    end else if (wr_en) begin
      storage[wr_addr] <= floor_destiny_Input;
    end
  end

  assign pos0Mem = mem_empty ? FLOOR_RESET : storage[head];

endmodule : floor_request_memory

// File: tb/tb_floor_request_memory.sv
// tb_floor_request_memory
//   Directed self-checking bench for floor_request_memory (DEPTH = 4).
//   Each scenario task drives its own stimulus and compares outputs against
//   hand-computed values. Build with DUPLICATE_FILTER_EN to exercise the
//   duplicate-filter expectations.
module tb_floor_request_memory;

  logic       clk;
  logic       reset;
  logic [1:0] floor_destiny_Input;
  logic       request_valid;
  logic       beginEndMemory_Flag;
  logic       floor_reached;
  logic [1:0] pos0Mem;
  logic [2:0] mem_count;
  logic       mem_empty;
  logic       mem_full;
  logic       overflow_Flag;
  logic       underflow_Flag;

  int n_checks = 0;
  int n_fails  = 0;

  floor_request_memory #(.DEPTH(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .floor_destiny_Input (floor_destiny_Input),
    .request_valid       (request_valid),
    .beginEndMemory_Flag (beginEndMemory_Flag),
    .floor_reached       (floor_reached),
    .pos0Mem             (pos0Mem),
    .mem_count           (mem_count),
    .mem_empty           (mem_empty),
    .mem_full            (mem_full),
    .overflow_Flag       (overflow_Flag),
    .underflow_Flag      (underflow_Flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus: inputs applied on the falling edge, sampled by
  // the DUT on the rising edge, outputs settled 1 time unit later.
  task automatic cycle(input logic rv, input logic [1:0] d, input logic front,
                       input logic pop, input logic rst);
    @(negedge clk);
    reset               = rst;
    request_valid       = rv;
    floor_destiny_Input = d;
    beginEndMemory_Flag = front;
    floor_reached       = pop;
    @(posedge clk);
    #1;
    reset               = 1'b0;
    request_valid       = 1'b0;
    beginEndMemory_Flag = 1'b0;
    floor_reached       = 1'b0;
  endtask

  task automatic do_reset();
    // Strobes asserted alongside reset must have no effect.
    cycle(1'b1, 2'd3, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic push_back(input logic [1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pos0Mem !== 2'd0) begin n_fails++; $display("FAIL reset_pos0 got=%0d exp=0", pos0Mem); end
    n_checks++; if (mem_count !== 3'd0) begin n_fails++; $display("FAIL reset_count got=%0d exp=0", mem_count); end
    n_checks++; if (mem_empty !== 1'b1) begin n_fails++; $display("FAIL reset_empty got=%b exp=1", mem_empty); end
    n_checks++; if (mem_full !== 1'b0) begin n_fails++; $display("FAIL reset_full got=%b exp=0", mem_full); end
    n_checks++; if (overflow_Flag !== 1'b0) begin n_fails++; $display("FAIL reset_ovf got=%b exp=0", overflow_Flag); end
    n_checks++; if (underflow_Flag !== 1'b0) begin n_fails++; $display("FAIL reset_unf got=%b exp=0", underflow_Flag); end
  endtask

  task automatic test_push_back_order();
    logic [1:0] exp_front [3];
    exp_front[0] = 2'd3; exp_front[1] = 2'd1; exp_front[2] = 2'd0;
    do_reset();
    push_back(2'd2);
    push_back(2'd3);
    push_back(2'd1);
    n_checks++; if (pos0Mem !== 2'd2) begin n_fails++; $display("FAIL order_pos0 got=%0d exp=2", pos0Mem); end
    n_checks++; if (mem_count !== 3'd3) begin n_fails++; $display("FAIL order_count got=%0d exp=3", mem_count); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (pos0Mem !== exp_front[i]) begin n_fails++; $display("FAIL order_pop%0d got=%0d exp=%0d", i, pos0Mem, exp_front[i]); end
    end
    n_checks++; if (mem_empty !== 1'b1) begin n_fails++; $display("FAIL order_empty got=%b exp=1", mem_empty); end
  endtask

  task automatic test_push_front();
    do_reset();
    push_back(2'd3);
    cycle(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);  // head wraps 0 -> 3
    n_checks++; if (pos0Mem !== 2'd1) begin n_fails++; $display("FAIL front_pos0 got=%0d exp=1", pos0Mem); end
    n_checks++; if (mem_count !== 3'd2) begin n_fails++; $display("FAIL front_count got=%0d exp=2", mem_count); end
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (pos0Mem !== 2'd3) begin n_fails++; $display("FAIL front_pop_pos0 got=%0d exp=3", pos0Mem); end
    n_checks++; if (mem_count !== 3'd1) begin n_fails++; $display("FAIL front_pop_count got=%0d exp=1", mem_count); end
  endtask

  task automatic test_overflow();
    logic       exp_ovf;
    logic [1:0] exp_front [4];
    exp_front[0] = 2'd0; exp_front[1] = 2'd3; exp_front[2] = 2'd2; exp_front[3] = 2'd0;
`ifdef DUPLICATE_FILTER_EN
    exp_ovf = 1'b0;  // 2 is already stored: discarded as a duplicate, no pulse
`else
    exp_ovf = 1'b1;
`endif
    do_reset();
    push_back(2'd2);
    push_back(2'd1);
    push_back(2'd0);
    push_back(2'd3);
    n_checks++; if (mem_full !== 1'b1) begin n_fails++; $display("FAIL ovf_full got=%b exp=1", mem_full); end
    push_back(2'd2);
    n_checks++; if (overflow_Flag !== exp_ovf) begin n_fails++; $display("FAIL ovf_pulse got=%b exp=%b", overflow_Flag, exp_ovf); end
    n_checks++; if (mem_count !== 3'd4) begin n_fails++; $display("FAIL ovf_count got=%0d exp=4", mem_count); end
    n_checks++; if (pos0Mem !== 2'd2) begin n_fails++; $display("FAIL ovf_pos0 got=%0d exp=2", pos0Mem); end
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (overflow_Flag !== 1'b0) begin n_fails++; $display("FAIL ovf_clear got=%b exp=0", overflow_Flag); end
    // Pop 2 and push 2 at the back in the same cycle while full.
    cycle(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    n_checks++; if (mem_count !== 3'd4) begin n_fails++; $display("FAIL popush_count got=%0d exp=4", mem_count); end
    n_checks++; if (overflow_Flag !== 1'b0) begin n_fails++; $display("FAIL popush_ovf got=%b exp=0", overflow_Flag); end
    n_checks++; if (pos0Mem !== 2'd1) begin n_fails++; $display("FAIL popush_pos0 got=%0d exp=1", pos0Mem); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (pos0Mem !== exp_front[i]) begin n_fails++; $display("FAIL popush_drain%0d got=%0d exp=%0d", i, pos0Mem, exp_front[i]); end
    end
    n_checks++; if (mem_empty !== 1'b1) begin n_fails++; $display("FAIL popush_empty got=%b exp=1", mem_empty); end
  endtask

  task automatic test_underflow_wrap();
    do_reset();
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (underflow_Flag !== 1'b1) begin n_fails++; $display("FAIL unf_pulse got=%b exp=1", underflow_Flag); end
    n_checks++; if (mem_count !== 3'd0) begin n_fails++; $display("FAIL unf_count got=%0d exp=0", mem_count); end
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (underflow_Flag !== 1'b0) begin n_fails++; $display("FAIL unf_clear got=%b exp=0", underflow_Flag); end
    // Move head to slot 3 holding floor 3, then push front into slot 2.
    push_back(2'd0);
    push_back(2'd1);
    push_back(2'd2);
    push_back(2'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (pos0Mem !== 2'd3) begin n_fails++; $display("FAIL wrap_head3 got=%0d exp=3", pos0Mem); end
    cycle(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    n_checks++; if (pos0Mem !== 2'd1) begin n_fails++; $display("FAIL wrap_front got=%0d exp=1", pos0Mem); end
    n_checks++; if (mem_count !== 3'd2) begin n_fails++; $display("FAIL wrap_count got=%0d exp=2", mem_count); end
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (pos0Mem !== 2'd3) begin n_fails++; $display("FAIL wrap_pop got=%0d exp=3", pos0Mem); end
    // Pop + push on an empty store: pop ignored, push lands.
    do_reset();
    cycle(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    n_checks++; if (underflow_Flag !== 1'b1) begin n_fails++; $display("FAIL empty_popush_unf got=%b exp=1", underflow_Flag); end
    n_checks++; if (mem_count !== 3'd1) begin n_fails++; $display("FAIL empty_popush_count got=%0d exp=1", mem_count); end
    n_checks++; if (pos0Mem !== 2'd2) begin n_fails++; $display("FAIL empty_popush_pos0 got=%0d exp=2", pos0Mem); end
  endtask

  task automatic test_pop_push_front();
    do_reset();
    push_back(2'd1);
    push_back(2'd3);
    cycle(1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (pos0Mem !== 2'd0) begin n_fails++; $display("FAIL ppf_pos0 got=%0d exp=0", pos0Mem); end
    n_checks++; if (mem_count !== 3'd2) begin n_fails++; $display("FAIL ppf_count got=%0d exp=2", mem_count); end
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (pos0Mem !== 2'd3) begin n_fails++; $display("FAIL ppf_next got=%0d exp=3", pos0Mem); end
  endtask

  task automatic test_duplicate_and_reset();
    logic [2:0] exp_cnt_dup;
    logic [2:0] exp_cnt_repl;
`ifdef DUPLICATE_FILTER_EN
    exp_cnt_dup  = 3'd2;  // {2,3}: 3 rejected
    exp_cnt_repl = 3'd2;  // pop 2 + push 2 -> {3,2}
`else
    exp_cnt_dup  = 3'd3;  // {2,3,3}
    exp_cnt_repl = 3'd3;  // {3,3,2}
`endif
    do_reset();
    push_back(2'd2);
    push_back(2'd3);
    push_back(2'd3);
    n_checks++; if (mem_count !== exp_cnt_dup) begin n_fails++; $display("FAIL dup_count got=%0d exp=%0d", mem_count, exp_cnt_dup); end
    n_checks++; if (overflow_Flag !== 1'b0) begin n_fails++; $display("FAIL dup_ovf got=%b exp=0", overflow_Flag); end
    cycle(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    n_checks++; if (mem_count !== exp_cnt_repl) begin n_fails++; $display("FAIL dup_popped_count got=%0d exp=%0d", mem_count, exp_cnt_repl); end
    n_checks++; if (pos0Mem !== 2'd3) begin n_fails++; $display("FAIL dup_popped_pos0 got=%0d exp=3", pos0Mem); end
    // Reset in the middle of activity clears everything in one cycle.
    do_reset();
    n_checks++; if (mem_count !== 3'd0) begin n_fails++; $display("FAIL mid_reset_count got=%0d exp=0", mem_count); end
    n_checks++; if (pos0Mem !== 2'd0) begin n_fails++; $display("FAIL mid_reset_pos0 got=%0d exp=0", pos0Mem); end
    n_checks++; if (mem_empty !== 1'b1) begin n_fails++; $display("FAIL mid_reset_empty got=%b exp=1", mem_empty); end
    n_checks++; if (underflow_Flag !== 1'b0) begin n_fails++; $display("FAIL mid_reset_unf got=%b exp=0", underflow_Flag); end
  endtask

  initial begin
    reset               = 1'b1;
    request_valid       = 1'b0;
    floor_destiny_Input = 2'd0;
    beginEndMemory_Flag = 1'b0;
    floor_reached       = 1'b0;
    test_reset();
    test_push_back_order();
    test_push_front();
    test_overflow();
    test_underflow_wrap();
    test_pop_push_front();
    test_duplicate_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_floor_request_memory
